// File: rtl/vec_ctrl_decoder_pkg.sv
// Shared definitions for the vector instruction decoder: instruction layout,
// opcodes, register indices and FSM state encoding.
package vec_ctrl_decoder_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ADD   = 2'b10,
      OP_MUL   = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      REG_A1 = 2'b00,
      REG_A2 = 2'b01,
      REG_A3 = 2'b10,
      REG_A4 = 2'b11
   } vreg_e;

   // Packed view of the 9-bit instruction: [8:7] opcode, [6:5] reg, [4:0] block
   typedef struct packed {
      opcode_e    op;
      vreg_e      rsel;
      logic [4:0] block;
   } instr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEM_RD,
      S_MEM_WAIT,
      S_RF_WB,
      S_ST,
      S_EXEC,
      S_ALU_WAIT,
      S_ALU_WB
   } state_e;

   function automatic logic [8:0] block_addr(input logic [4:0] blk);
      return {blk, 4'b0000};
   endfunction

endpackage

// File: rtl/vec_ctrl_decoder_wait_counter.sv
// Loadable down-counter with a zero flag; shared by the memory-latency and
// ALU-timeout waits.
module vec_wait_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/vec_ctrl_decoder.sv
// Vector instruction decoder: accepts one 9-bit instruction per handshake and
// sequences the memory, register-file and ALU strobes to execute it.
module vec_ctrl_decoder #(
   parameter int unsigned MEM_LAT     = 1,
   parameter int unsigned ALU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8:0]       instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [8:0]       mem_addr,
   output logic             mem_rd_en,
   output logic             mem_wr_en,
   output logic [1:0]       rf_rd_sel,
   output logic             rf_wr_en,
   output logic [1:0]       rf_wr_sel,
   output logic             rf_wr_pair,
   output logic             alu_start,
   output logic             alu_op,
   input  logic             alu_done,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] instr_count
);

   import vec_ctrl_decoder_pkg::*;

   localparam int unsigned MAX_WAIT = (ALU_TIMEOUT > MEM_LAT) ? ALU_TIMEOUT : MEM_LAT;
   localparam int unsigned CW       = $clog2(MAX_WAIT + 1);
   // MEM_WAIT spans MEM_LAT-1 cycles: the count runs from MEM_LAT-2 down to 0
   localparam logic [CW-1:0] MEM_INIT = CW'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
   localparam logic [CW-1:0] ALU_INIT = CW'(ALU_TIMEOUT - 1);

   state_e      state;
   instr_t      dec_in;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   logic [CW-1:0] cnt_val;

   assign dec_in = instr_t'(instr);

   always_comb begin
      cnt_load = (state == S_MEM_RD) || (state == S_EXEC);
      cnt_dec  = (state == S_MEM_WAIT) || (state == S_ALU_WAIT);
      cnt_val  = (state == S_EXEC) ? ALU_INIT : MEM_INIT;
   end

   vec_wait_counter #(
      .W (CW)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Outputs are computed for the state being entered, so each is registered
   // and lines up with the cycle the FSM spends in that state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         mem_wr_en   <= 1'b0;
         rf_rd_sel   <= '0;
         rf_wr_en    <= 1'b0;
         rf_wr_sel   <= '0;
         rf_wr_pair  <= 1'b0;
         alu_start   <= 1'b0;
         alu_op      <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         instr_count <= '0;
      end else begin
         mem_rd_en  <= 1'b0;
         mem_wr_en  <= 1'b0;
         rf_wr_en   <= 1'b0;
         rf_wr_pair <= 1'b0;
         alu_start  <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (instr_valid && instr_ready) begin
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  unique case (dec_in.op)
                     OP_LOAD: begin
                        state     <= S_MEM_RD;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= block_addr(dec_in.block);
                        rf_wr_sel <= dec_in.rsel;
                     end
                     OP_STORE: begin
                        state     <= S_ST;
                        mem_wr_en <= 1'b1;
                        mem_addr  <= block_addr(dec_in.block);
                        rf_rd_sel <= dec_in.rsel;
                     end
                     default: begin
                        state     <= S_EXEC;
                        alu_start <= 1'b1;
                        alu_op    <= (dec_in.op == OP_MUL);
                        mem_addr  <= '0;
                     end
                  endcase
               end
            end
            S_MEM_RD: begin
               if (MEM_LAT == 1) begin
                  state    <= S_RF_WB;
                  rf_wr_en <= 1'b1;
               end else begin
                  state <= S_MEM_WAIT;
               end
            end
            S_MEM_WAIT: begin
               if (cnt_zero) begin
                  state    <= S_RF_WB;
                  rf_wr_en <= 1'b1;
               end
            end
            S_EXEC: begin
               state <= S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
               if (alu_done) begin
                  state      <= S_ALU_WB;
                  rf_wr_pair <= 1'b1;
               end else if (cnt_zero) begin
                  state       <= S_IDLE;
                  timeout_err <= 1'b1;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            S_RF_WB, S_ST, S_ALU_WB: begin
               state       <= S_IDLE;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               instr_count <= instr_count + CNT_W'(1);
            end
            default: begin
               state       <= S_IDLE;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_ctrl_decoder.sv
// Directed self-checking bench for vec_ctrl_decoder: one instance with
// single-cycle memory, one with 3-cycle memory and a narrow retire counter.
module tb_vec_ctrl_decoder;

   logic       clk;
   logic       rst;

   logic [8:0] a_instr;
   logic       a_valid, a_ready, a_rd, a_wr, a_rfw, a_pair, a_start, a_op, a_done;
   logic       a_busy, a_terr;
   logic [8:0] a_addr;
   logic [1:0] a_rsel, a_wsel;
   logic [15:0] a_count;

   logic [8:0] b_instr;
   logic       b_valid, b_ready, b_rd, b_wr, b_rfw, b_pair, b_start, b_op, b_done;
   logic       b_busy, b_terr;
   logic [8:0] b_addr;
   logic [1:0] b_rsel, b_wsel;
   logic [3:0] b_count;

   int checks = 0;
   int errors = 0;

   int a_rd_n = 0, a_wr_n = 0, a_rfw_n = 0, a_pair_n = 0, a_start_n = 0, a_multi = 0;
   int b_rfw_n = 0, b_multi = 0;

   vec_ctrl_decoder #(
      .MEM_LAT     (1),
      .ALU_TIMEOUT (4),
      .CNT_W       (16)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .instr       (a_instr),
      .instr_valid (a_valid),
      .instr_ready (a_ready),
      .mem_addr    (a_addr),
      .mem_rd_en   (a_rd),
      .mem_wr_en   (a_wr),
      .rf_rd_sel   (a_rsel),
      .rf_wr_en    (a_rfw),
      .rf_wr_sel   (a_wsel),
      .rf_wr_pair  (a_pair),
      .alu_start   (a_start),
      .alu_op      (a_op),
      .alu_done    (a_done),
      .busy        (a_busy),
      .timeout_err (a_terr),
      .instr_count (a_count)
   );

   vec_ctrl_decoder #(
      .MEM_LAT     (3),
      .ALU_TIMEOUT (4),
      .CNT_W       (4)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .instr       (b_instr),
      .instr_valid (b_valid),
      .instr_ready (b_ready),
      .mem_addr    (b_addr),
      .mem_rd_en   (b_rd),
      .mem_wr_en   (b_wr),
      .rf_rd_sel   (b_rsel),
      .rf_wr_en    (b_rfw),
      .rf_wr_sel   (b_wsel),
      .rf_wr_pair  (b_pair),
      .alu_start   (b_start),
      .alu_op      (b_op),
      .alu_done    (b_done),
      .busy        (b_busy),
      .timeout_err (b_terr),
      .instr_count (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe tallies sampled mid-cycle
   always @(negedge clk) begin
      a_rd_n    += int'(a_rd);
      a_wr_n    += int'(a_wr);
      a_rfw_n   += int'(a_rfw);
      a_pair_n  += int'(a_pair);
      a_start_n += int'(a_start);
      b_rfw_n   += int'(b_rfw);
      if ($countones({a_rd, a_wr, a_rfw, a_pair, a_start}) > 1) a_multi++;
      if ($countones({b_rd, b_wr, b_rfw, b_pair, b_start}) > 1) b_multi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({a_ready, a_busy, a_rd, a_wr, a_rfw, a_pair, a_start, a_op, a_terr} !== 9'b100000000) begin
         errors++;
         $display("FAIL reset_ctrl_a: got %b expected %b",
                  {a_ready, a_busy, a_rd, a_wr, a_rfw, a_pair, a_start, a_op, a_terr}, 9'b100000000);
      end
      checks++;
      if ({a_addr, a_rsel, a_wsel, a_count} !== 29'd0) begin
         errors++;
         $display("FAIL reset_data_a: addr=%0d rsel=%0d wsel=%0d count=%0d expected all 0",
                  a_addr, a_rsel, a_wsel, a_count);
      end
      checks++;
      if ({b_ready, b_busy, b_rd, b_wr, b_rfw, b_pair, b_start, b_op, b_terr, b_count} !== 13'b1000000000000) begin
         errors++;
         $display("FAIL reset_b: got %b expected %b",
                  {b_ready, b_busy, b_rd, b_wr, b_rfw, b_pair, b_start, b_op, b_terr, b_count},
                  13'b1000000000000);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({a_ready, a_busy} !== 2'b10) begin
         errors++;
         $display("FAIL idle_after_reset: ready/busy=%b expected 10", {a_ready, a_busy});
      end
   endtask

   task automatic test_load();
      a_instr = 9'b000100001;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_rd, a_wr, a_rfw, a_pair, a_start, a_ready, a_busy} !== 7'b1000001 || a_addr !== 9'd16) begin
         errors++;
         $display("FAIL load_t1: strobes/ready/busy=%b addr=%0d expected 1000001 addr=16",
                  {a_rd, a_wr, a_rfw, a_pair, a_start, a_ready, a_busy}, a_addr);
      end
      tick();
      checks++;
      if ({a_rd, a_wr, a_rfw, a_pair, a_start} !== 5'b00100 || a_wsel !== 2'd1 || a_count !== 16'd0) begin
         errors++;
         $display("FAIL load_t2: strobes=%b wsel=%0d count=%0d expected 00100 wsel=1 count=0",
                  {a_rd, a_wr, a_rfw, a_pair, a_start}, a_wsel, a_count);
      end
      tick();
      checks++;
      if ({a_ready, a_busy, a_rd, a_wr, a_rfw, a_pair, a_start} !== 7'b1000000 || a_count !== 16'd1) begin
         errors++;
         $display("FAIL load_t3: ready/busy/strobes=%b count=%0d expected 1000000 count=1",
                  {a_ready, a_busy, a_rd, a_wr, a_rfw, a_pair, a_start}, a_count);
      end
   endtask

   task automatic test_store();
      a_instr = 9'b011000010;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_rd, a_wr, a_rfw, a_pair, a_start} !== 5'b01000 || a_addr !== 9'd32 || a_rsel !== 2'd2) begin
         errors++;
         $display("FAIL store_t1: strobes=%b addr=%0d rsel=%0d expected 01000 addr=32 rsel=2",
                  {a_rd, a_wr, a_rfw, a_pair, a_start}, a_addr, a_rsel);
      end
      tick();
      checks++;
      if ({a_ready, a_busy, a_wr} !== 3'b100 || a_count !== 16'd2) begin
         errors++;
         $display("FAIL store_t2: ready/busy/wr=%b count=%0d expected 100 count=2",
                  {a_ready, a_busy, a_wr}, a_count);
      end
   endtask

   task automatic test_mul();
      int rd0, wr0, rfw0, pair0, start0;
      rd0 = a_rd_n; wr0 = a_wr_n; rfw0 = a_rfw_n; pair0 = a_pair_n; start0 = a_start_n;
      a_instr = 9'b110000000;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_start, a_op} !== 2'b11 || a_addr !== 9'd0) begin
         errors++;
         $display("FAIL mul_start: start/op=%b addr=%0d expected 11 addr=0", {a_start, a_op}, a_addr);
      end
      tick();
      tick();
      tick();
      a_done = 1'b1;
      checks++;
      if (a_pair !== 1'b0 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL mul_wait: pair=%b busy=%b expected 0 1", a_pair, a_busy);
      end
      tick();
      a_done = 1'b0;
      checks++;
      if ({a_rd, a_wr, a_rfw, a_pair, a_start} !== 5'b00010) begin
         errors++;
         $display("FAIL mul_writeback: strobes=%b expected 00010", {a_rd, a_wr, a_rfw, a_pair, a_start});
      end
      tick();
      checks++;
      if (a_ready !== 1'b1 || a_count !== 16'd3) begin
         errors++;
         $display("FAIL mul_retire: ready=%b count=%0d expected 1 count=3", a_ready, a_count);
      end
      checks++;
      if ((a_rd_n - rd0) != 0 || (a_wr_n - wr0) != 0 || (a_rfw_n - rfw0) != 0 ||
          (a_pair_n - pair0) != 1 || (a_start_n - start0) != 1) begin
         errors++;
         $display("FAIL mul_strobe_counts: rd=%0d wr=%0d rfw=%0d pair=%0d start=%0d expected 0 0 0 1 1",
                  a_rd_n - rd0, a_wr_n - wr0, a_rfw_n - rfw0, a_pair_n - pair0, a_start_n - start0);
      end
   endtask

   task automatic test_timeout();
      int pair0;
      pair0 = a_pair_n;
      a_instr = 9'b100000000;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      a_done  = 1'b1;
      checks++;
      if ({a_start, a_op} !== 2'b10) begin
         errors++;
         $display("FAIL add_start: start/op=%b expected 10", {a_start, a_op});
      end
      tick();
      a_done = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({a_terr, a_busy} !== 2'b01) begin
         errors++;
         $display("FAIL timeout_early: terr/busy=%b expected 01", {a_terr, a_busy});
      end
      tick();
      checks++;
      if ({a_terr, a_ready, a_busy, a_pair} !== 4'b1100) begin
         errors++;
         $display("FAIL timeout_set: terr/ready/busy/pair=%b expected 1100", {a_terr, a_ready, a_busy, a_pair});
      end
      checks++;
      if (a_count !== 16'd3 || a_pair_n != pair0) begin
         errors++;
         $display("FAIL timeout_no_retire: count=%0d pairs=%0d expected count=3 pairs=0",
                  a_count, a_pair_n - pair0);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] seq [5];
      logic [8:0] addrs [$];
      logic [1:0] sels [$];
      int  idx, cyc;
      bit  acc, start_seen;
      seq[0] = 9'b000000000;
      seq[1] = 9'b000100001;
      seq[2] = 9'b110000000;
      seq[3] = 9'b011000010;
      seq[4] = 9'b011100011;
      idx = 0; cyc = 0; start_seen = 1'b0;
      a_instr = seq[0];
      a_valid = 1'b1;
      while (!(idx == 5 && a_ready) && cyc < 100) begin
         acc = a_valid && a_ready;
         tick();
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 5) a_instr = seq[idx];
            else         a_valid = 1'b0;
         end
         a_done     = start_seen;
         start_seen = a_start;
         if (a_rd || a_wr) addrs.push_back(a_addr);
         if (a_rfw) sels.push_back(a_wsel);
         if (a_wr)  sels.push_back(a_rsel);
      end
      a_done  = 1'b0;
      a_valid = 1'b0;
      checks++;
      if (cyc != 14) begin
         errors++;
         $display("FAIL b2b_cycles: took %0d cycles expected 14 (budget 100)", cyc);
      end
      checks++;
      if (a_count !== 16'd8) begin
         errors++;
         $display("FAIL b2b_count: count=%0d expected 8", a_count);
      end
      checks++;
      if (addrs.size() != 4 || {addrs[0], addrs[1], addrs[2], addrs[3]} !== {9'd0, 9'd16, 9'd32, 9'd48}) begin
         errors++;
         $display("FAIL b2b_addrs: %0d addresses seen, expected 0,16,32,48", addrs.size());
      end
      checks++;
      if (sels.size() != 4 || {sels[0], sels[1], sels[2], sels[3]} !== 8'b00011011) begin
         errors++;
         $display("FAIL b2b_regsel: %0d selects seen, expected 0,1,2,3", sels.size());
      end
      checks++;
      if (a_terr !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: terr=%b expected 1", a_terr);
      end
   endtask

   task automatic test_load_lat3();
      b_instr = 9'b000100001;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      checks++;
      if ({b_rd, b_rfw} !== 2'b10 || b_addr !== 9'd16) begin
         errors++;
         $display("FAIL lat3_rd: rd/rfw=%b addr=%0d expected 10 addr=16", {b_rd, b_rfw}, b_addr);
      end
      tick();
      tick();
      checks++;
      if ({b_rd, b_rfw, b_busy} !== 3'b001) begin
         errors++;
         $display("FAIL lat3_wait: rd/rfw/busy=%b expected 001", {b_rd, b_rfw, b_busy});
      end
      tick();
      checks++;
      if (b_rfw !== 1'b1 || b_wsel !== 2'd1) begin
         errors++;
         $display("FAIL lat3_wb: rfw=%b wsel=%0d expected 1 wsel=1", b_rfw, b_wsel);
      end
      tick();
      checks++;
      if (b_ready !== 1'b1 || b_count !== 4'd1) begin
         errors++;
         $display("FAIL lat3_retire: ready=%b count=%0d expected 1 count=1", b_ready, b_count);
      end
   endtask

   task automatic test_rst_mid();
      int rfw0;
      b_instr = 9'b000100001;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      rfw0 = b_rfw_n;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({b_ready, b_busy, b_rd, b_rfw} !== 4'b1000 || b_count !== 4'd0) begin
         errors++;
         $display("FAIL rst_mid_state: ready/busy/rd/rfw=%b count=%0d expected 1000 count=0",
                  {b_ready, b_busy, b_rd, b_rfw}, b_count);
      end
      checks++;
      if (a_terr !== 1'b0 || a_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_clears_a: terr=%b count=%0d expected 0 0", a_terr, a_count);
      end
      rst = 1'b0;
      repeat (6) tick();
      checks++;
      if (b_rfw_n != rfw0 || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_no_wb: late rf writes=%0d busy=%b expected 0 0", b_rfw_n - rfw0, b_busy);
      end
   endtask

   task automatic test_count_wrap();
      b_instr = 9'b010000101;
      for (int i = 0; i < 15; i++) begin
         b_valid = 1'b1;
         tick();
         b_valid = 1'b0;
         tick();
      end
      checks++;
      if (b_count !== 4'd15) begin
         errors++;
         $display("FAIL count_max: count=%0d expected 15", b_count);
      end
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      checks++;
      if (b_count !== 4'd0) begin
         errors++;
         $display("FAIL count_wrap: count=%0d expected 0", b_count);
      end
   endtask

   task automatic test_strobe_exclusive();
      checks++;
      if (a_multi != 0 || b_multi != 0) begin
         errors++;
         $display("FAIL strobe_exclusive: overlapping-strobe cycles a=%0d b=%0d expected 0 0", a_multi, b_multi);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_instr = '0; a_valid = 1'b0; a_done = 1'b0;
      b_instr = '0; b_valid = 1'b0; b_done = 1'b0;
      test_reset();
      test_load();
      test_store();
      test_mul();
      test_timeout();
      test_back_to_back();
      test_load_lat3();
      test_rst_mid();
      test_count_wrap();
      test_strobe_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
